sequence_1010_generator: RTL and testbench

Serial pattern transmitter that drives the `x` input of the 1010 sequence detectors in the FSM set, including the overlapping variant. It loads a parallel pattern on a `start` pulse and shifts it out MSB-first, one bit per clock. It repeats the pattern a programmed number of times, with an optional idle gap between repetitions, and signals completion. It acts as the stimulus source paired with the detector, both in self-checking benches and in loopback top levels.

---
 rtl/sequence_gen_pkg.sv | 15 +
 rtl/sequence_1010_generator_piso.sv | 30 +++
 rtl/sequence_1010_generator.sv | 141 ++++++++++++++
 tb/tb_sequence_1010_generator.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sequence_gen_pkg.sv
// Shared types and constants for the serial 1010 pattern generator.
// Holds the FSM state encoding, the default pattern and the bit-counter width.
package sequence_gen_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam int PAT_W_DEF = 4;
    localparam logic [PAT_W_DEF-1:0] DEFAULT_PAT = 4'b1010;
    localparam int BIT_CNT_W = $clog2(PAT_W_DEF);

endpackage

// File: rtl/sequence_1010_generator_piso.sv
// Parallel-in / serial-out register, MSB first, zero-filled on shift.
// Priority: clear > load > shift.
module piso_shift_reg #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         shift,
    input  logic         clear,
    input  logic [W-1:0] din,
    output logic         msb
);

    logic [W-1:0] sr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            sr <= '0;
        else if (clear)
            sr <= '0;
        else if (load)
            sr <= din;
        else if (shift)
            sr <= {sr[W-2:0], 1'b0};
    end

    assign msb = sr[W-1];

endmodule

// File: rtl/sequence_1010_generator.sv
// Serial pattern transmitter: loads a pattern on start and shifts it out
// MSB-first, repeated repeat_cnt times with an optional idle gap.
module sequence_1010_generator
    import sequence_gen_pkg::*;
#(
    parameter int                 PAT_W       = 4,
    parameter logic [PAT_W-1:0]   DEFAULT_PAT = sequence_gen_pkg::DEFAULT_PAT,
    parameter int                 CNT_W       = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [PAT_W-1:0] pattern,
    input  logic [CNT_W-1:0] repeat_cnt,
    input  logic [CNT_W-1:0] gap_cyc,
    input  logic             abort,
    output logic             x,
    output logic             x_valid,
    output logic             busy,
    output logic             done
);

    localparam int BW = (PAT_W > 1) ? $clog2(PAT_W) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(PAT_W - 1);

    state_t           state, state_nx;
    logic [BW-1:0]    bit_cnt;
    logic [CNT_W-1:0] rep_left;
    logic [CNT_W-1:0] gap_cap;
    logic [CNT_W-1:0] gap_left;
    logic [PAT_W-1:0] pat_cap;

    logic accept, last_bit, last_rep, gap_end, gap_zero;
    logic sr_load, sr_shift, sr_clear;
    logic [PAT_W-1:0] sr_din;
    logic x_valid_nx, busy_nx, done_nx;

    assign accept   = (state == IDLE) && start && !abort && (repeat_cnt != '0);
    assign last_bit = (state == SEND) && (bit_cnt == LAST_BIT);
    assign last_rep = (rep_left == CNT_W'(1));
    assign gap_zero = (gap_cap == '0);
    assign gap_end  = (state == GAP) && (gap_left == CNT_W'(1));

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (accept) state_nx = SEND;
            SEND: begin
                if (abort)
                    state_nx = IDLE;
                else if (last_bit)
                    state_nx = last_rep ? IDLE : (gap_zero ? SEND : GAP);
            end
            GAP: begin
                if (abort)
                    state_nx = IDLE;
                else if (gap_end)
                    state_nx = SEND;
            end
            default: state_nx = IDLE;
        endcase
    end

    // output / datapath control; outputs are registered below
    always_comb begin
        sr_clear   = abort && (state != IDLE);
        sr_load    = accept
                   || (last_bit && !last_rep && gap_zero)
                   || gap_end;
        sr_shift   = (state == SEND);
        sr_din     = accept ? ((pattern == '0) ? DEFAULT_PAT : pattern) : pat_cap;
        x_valid_nx = (state_nx == SEND);
        busy_nx    = (state_nx != IDLE);
        done_nx    = last_bit && last_rep && !abort;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_valid <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            x_valid <= x_valid_nx;
            busy    <= busy_nx;
            done    <= done_nx;
        end
    end

    // counters and captured parameters; decrements are guarded so nothing wraps
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt  <= '0;
            rep_left <= '0;
            gap_cap  <= '0;
            gap_left <= '0;
            pat_cap  <= '0;
        end else begin
            if (sr_load || state_nx != SEND)
                bit_cnt <= '0;
            else if (state == SEND && !last_bit)
                bit_cnt <= bit_cnt + BW'(1);

            if (accept) begin
                rep_left <= repeat_cnt;
                gap_cap  <= gap_cyc;
                pat_cap  <= (pattern == '0) ? DEFAULT_PAT : pattern;
            end else if (state_nx == IDLE) begin
                rep_left <= '0;
            end else if (last_bit && !last_rep) begin
                rep_left <= rep_left - CNT_W'(1);
            end

            if (state == SEND && state_nx == GAP)
                gap_left <= gap_cap;
            else if (state == GAP && state_nx == GAP)
                gap_left <= gap_left - CNT_W'(1);
            else
                gap_left <= '0;
        end
    end

    piso_shift_reg #(.W(PAT_W)) u_piso (
        .clk   (clk),
        .rst   (rst),
        .load  (sr_load),
        .shift (sr_shift),
        .clear (sr_clear),
        .din   (sr_din),
        .msb   (x)
    );

endmodule

// File: tb/tb_sequence_1010_generator.sv
// Directed bench for sequence_1010_generator; each task checks one scenario
// against hand-computed bit streams.
module tb_sequence_1010_generator;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] pattern;
    logic [3:0] repeat_cnt;
    logic [3:0] gap_cyc;
    logic       abort;
    logic       x, x_valid, busy, done;

    int checks   = 0;
    int failures = 0;

    sequence_1010_generator #(.PAT_W(4), .CNT_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .pattern    (pattern),
        .repeat_cnt (repeat_cnt),
        .gap_cyc    (gap_cyc),
        .abort      (abort),
        .x          (x),
        .x_valid    (x_valid),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [3:0] p, input logic [3:0] r, input logic [3:0] g);
        pattern = p; repeat_cnt = r; gap_cyc = g; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        pattern = '0; repeat_cnt = '0; gap_cyc = '0;
        tick(); tick();
        checks++;
        if ({x, x_valid, busy, done} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_state got x/v/b/d=%b want 0000", {x, x_valid, busy, done});
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_send();
        logic [3:0] exp_bits;
        exp_bits = 4'b1010;
        do_start(4'b1010, 4'd1, 4'd0);
        tick();
        #3 rst = 1'b1;
        #1;
        checks++;
        if ({x, x_valid, busy} !== 3'b000) begin
            failures++;
            $display("FAIL async_reset got x/v/b=%b want 000", {x, x_valid, busy});
        end
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (done !== 1'b0) begin
                failures++;
                $display("FAIL reset_no_done cyc=%0d got %b want 0", i, done);
            end
            tick();
        end
        do_start(4'b1010, 4'd1, 4'd0);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (x !== exp_bits[3-i] || x_valid !== 1'b1) begin
                failures++;
                $display("FAIL post_reset_bit%0d got x=%b v=%b want x=%b v=1", i, x, x_valid, exp_bits[3-i]);
            end
            tick();
        end
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL post_reset_done got %b want 1", done);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_bits, hits, exp_hits;
        logic [3:0] win;
        exp_bits = 8'b1010_1010;
        exp_hits = 8'b1010_1000;
        hits = '0; win = '0;
        do_start(4'b1010, 4'd2, 4'd0);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (x !== exp_bits[7-i] || x_valid !== 1'b1 || busy !== 1'b1 || done !== 1'b0) begin
                failures++;
                $display("FAIL b2b_bit%0d got x/v/b/d=%b%b%b%b want %b110", i, x, x_valid, busy, done, exp_bits[7-i]);
            end
            if (x_valid) begin
                win = {win[2:0], x};
                if (win == 4'b1010) hits[i] = 1'b1;
            end
            tick();
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || x_valid !== 1'b0) begin
            failures++;
            $display("FAIL b2b_done got d/b/v=%b%b%b want 100", done, busy, x_valid);
        end
        checks++;
        if (hits !== exp_hits) begin
            failures++;
            $display("FAIL b2b_detect got hits=%b want %b", hits, exp_hits);
        end
        tick();
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL b2b_done_pulse got %b want 0", done);
        end
    endtask

    task automatic test_gap();
        logic [10:0] exp_x, exp_v;
        exp_x = 11'b1010_000_1010;
        exp_v = 11'b1111_000_1111;
        do_start(4'b1010, 4'd2, 4'd3);
        for (int i = 0; i < 11; i++) begin
            checks++;
            if (x !== exp_x[10-i] || x_valid !== exp_v[10-i] || busy !== 1'b1 || done !== 1'b0) begin
                failures++;
                $display("FAIL gap_cyc%0d got x/v/b/d=%b%b%b%b want %b%b10", i, x, x_valid, busy, done, exp_x[10-i], exp_v[10-i]);
            end
            tick();
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL gap_done got d/b=%b%b want 10", done, busy);
        end
        tick();
    endtask

    task automatic test_default_zero();
        logic [3:0] exp_bits;
        exp_bits = 4'b1010;
        do_start(4'b0000, 4'd1, 4'd0);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (x !== exp_bits[3-i] || x_valid !== 1'b1) begin
                failures++;
                $display("FAIL default_bit%0d got x=%b v=%b want x=%b v=1", i, x, x_valid, exp_bits[3-i]);
            end
            tick();
        end
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL default_done got %b want 1", done);
        end
        tick();
        do_start(4'b1010, 4'd0, 4'd0);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({busy, done, x_valid} !== 3'b000) begin
                failures++;
                $display("FAIL zero_repeat cyc=%0d got b/d/v=%b want 000", i, {busy, done, x_valid});
            end
            tick();
        end
    endtask

    task automatic test_abort();
        logic [5:0] exp_bits;
        exp_bits = 6'b1100_11;
        do_start(4'b1100, 4'd3, 4'd0);
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (x !== exp_bits[5-i] || busy !== 1'b1) begin
                failures++;
                $display("FAIL abort_bit%0d got x=%b b=%b want x=%b b=1", i, x, busy, exp_bits[5-i]);
            end
            if (i == 1) begin
                start = 1'b1; pattern = 4'b0011; repeat_cnt = 4'd1; gap_cyc = 4'd5;
            end
            if (i == 5) abort = 1'b1;
            tick();
            start = 1'b0; abort = 1'b0;
        end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if ({x, x_valid, busy, done} !== 4'b0000) begin
                failures++;
                $display("FAIL abort_idle cyc=%0d got x/v/b/d=%b want 0000", i, {x, x_valid, busy, done});
            end
            tick();
        end
        // start and abort together in IDLE: nothing starts
        start = 1'b1; abort = 1'b1; pattern = 4'b1010; repeat_cnt = 4'd2;
        tick();
        start = 1'b0; abort = 1'b0;
        checks++;
        if ({x_valid, busy} !== 2'b00) begin
            failures++;
            $display("FAIL abort_start_idle got v/b=%b want 00", {x_valid, busy});
        end
        tick();
    endtask

    task automatic test_restart_on_done();
        logic [3:0] exp_bits;
        exp_bits = 4'b1001;
        do_start(4'b1010, 4'd1, 4'd0);
        tick(); tick(); tick(); tick();
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL restart_done got %b want 1", done);
        end
        start = 1'b1; pattern = 4'b1001; repeat_cnt = 4'd1; gap_cyc = 4'd0;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (x !== exp_bits[3-i] || x_valid !== 1'b1 || busy !== 1'b1 || done !== 1'b0) begin
                failures++;
                $display("FAIL restart_bit%0d got x/v/b/d=%b%b%b%b want %b110", i, x, x_valid, busy, done, exp_bits[3-i]);
            end
            tick();
        end
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL restart_done2 got %b want 1", done);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_reset_mid_send();
        test_back_to_back();
        test_gap();
        test_default_zero();
        test_abort();
        test_restart_on_done();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
